// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit for the execute stage: fixed-latency mult/div with busy/done
// handshake, plus direct mthi/mtlo writes to the architectural HI and LO registers.
module mul_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  op,
   input  logic        start,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [3:0]  count;
   logic [31:0] pend_hi;
   logic [31:0] pend_lo;
   logic        pend_wr;
   logic        is_muldiv;

   // Full 64-bit product; operands are sign- or zero-extended so one multiply serves both.
   function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] p;
      sa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
      sb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
      p  = sa * sb;
      return p;
   endfunction

   // Returns {remainder, quotient}; 64-bit extension makes 0x80000000 / -1 wrap to 0x80000000.
   function automatic logic [63:0] divrem64(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] q;
      logic signed [63:0] r;
      sa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
      sb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
      if (b == 32'd0) begin
         q = 64'sd0;
         r = 64'sd0;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
      return {r[31:0], q[31:0]};
   endfunction

   assign is_muldiv = start && (op >= OP_MULT) && (op <= OP_DIVU);
   assign busy      = is_muldiv || (count != 4'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= 4'd0;
         done    <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
      end else begin
         done <= 1'b0;
         if (count != 4'd0) begin
            // Any start arriving while running is dropped here, mthi/mtlo included.
            count <= count - 4'd1;
            if (count == 4'd1) begin
               if (pend_wr) begin
                  hi <= pend_hi;
                  lo <= pend_lo;
               end
               done <= 1'b1;
            end
         end else if (start) begin
            case (op)
               OP_MULT, OP_MULTU: begin
                  {pend_hi, pend_lo} <= mul64(rs_data, rt_data, op == OP_MULT);
                  pend_wr            <= 1'b1;
                  count              <= 4'(MULT_CYCLES);
               end
               OP_DIV, OP_DIVU: begin
                  {pend_hi, pend_lo} <= divrem64(rs_data, rt_data, op == OP_DIV);
                  pend_wr            <= (rt_data != 32'd0);
                  count              <= 4'(DIV_CYCLES);
               end
               OP_MTHI: hi <= rs_data;
               OP_MTLO: lo <= rs_data;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed sequences plus random traffic, every cycle compared
// against a deadline-based behavioural model using plain 64-bit arithmetic.
module tb_mul_div_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk;
   logic        reset;
   logic [2:0]  op;
   logic        start;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_tests;
   int n_fail;

   // model state
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   logic        m_done, m_active, p_wr;
   int          m_end, cyc, done_seen;

   mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .op(op), .start(start),
      .rs_data(rs_data), .rt_data(rt_data),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic s, input logic [2:0] o,
                             input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sp, sq, sr;
      longint unsigned ua, ub, up;
      if (r) begin
         m_hi = 0; m_lo = 0; m_done = 0; m_active = 0;
         p_hi = 0; p_lo = 0; p_wr = 0;
      end else begin
         m_done = 0;
         if (m_active && cyc == m_end) begin
            if (p_wr) begin
               m_hi = p_hi;
               m_lo = p_lo;
            end
            m_done   = 1;
            m_active = 0;
         end else if (!m_active && s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ua = {32'b0, a};
            ub = {32'b0, b};
            case (o)
               3'd1: begin sp = sa * sb; {p_hi, p_lo} = sp; p_wr = 1; m_active = 1; m_end = cyc + MC; end
               3'd2: begin up = ua * ub; {p_hi, p_lo} = up; p_wr = 1; m_active = 1; m_end = cyc + MC; end
               3'd3: begin
                  p_wr = (b != 0);
                  if (p_wr) begin sq = sa / sb; sr = sa % sb; p_lo = sq[31:0]; p_hi = sr[31:0]; end
                  m_active = 1; m_end = cyc + DC;
               end
               3'd4: begin
                  p_wr = (b != 0);
                  if (p_wr) begin p_lo = 32'(ua / ub); p_hi = 32'(ua % ub); end
                  m_active = 1; m_end = cyc + DC;
               end
               3'd5: m_hi = a;
               3'd6: m_lo = a;
               default: ;
            endcase
         end
      end
      cyc++;
   endtask

   // One clock cycle: drive, compare mid-cycle, then advance DUT and model together.
   task automatic step(input logic r, input logic s, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
      logic exp_busy;
      reset = r; start = s; op = o; rs_data = a; rt_data = b;
      #4;
      exp_busy = (s && o >= 3'd1 && o <= 3'd4) || m_active;
      check("busy", {31'b0, busy}, {31'b0, exp_busy});
      check("done", {31'b0, done}, {31'b0, m_done});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      if (done === 1'b1) done_seen++;
      @(posedge clk);
      model_edge(r, s, o, a, b);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; done_seen = 0;
      m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_done = 0; m_active = 0; p_wr = 0; m_end = 0;
      reset = 1; start = 0; op = 0; rs_data = 0; rt_data = 0;
      @(posedge clk); #1;
      step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);

      // mult -3 * 5
      step(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5);
      idle(MC);
      check("mult_done", {31'b0, done}, 32'd1);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFF1);
      idle(1);

      // multu max * max
      step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      idle(MC + 1);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);

      // div -7 / 2, divu 7 / 2
      step(1'b0, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
      idle(DC + 1);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);
      step(1'b0, 1'b1, 3'd4, 32'd7, 32'd2);
      idle(DC + 1);
      check("divu_lo", lo, 32'd3);
      check("divu_hi", hi, 32'd1);

      // overflow case of signed divide
      step(1'b0, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      idle(DC + 1);
      check("divovf_lo", lo, 32'h8000_0000);
      check("divovf_hi", hi, 32'd0);

      // mthi then divide by zero leaves HI/LO alone but still pulses done
      step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      step(1'b0, 1'b1, 3'd5, 32'h1234_5678, 32'd0);
      done_seen = 0;
      step(1'b0, 1'b1, 3'd4, 32'd99, 32'd0);
      idle(DC + 1);
      check("dz_done", 32'(done_seen), 32'd1);
      check("dz_hi", hi, 32'h1234_5678);
      check("dz_lo", lo, 32'd0);

      // starts while busy are ignored
      step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      step(1'b0, 1'b1, 3'd2, 32'd3, 32'd4);
      step(1'b0, 1'b1, 3'd6, 32'h0000_AAAA, 32'd0);
      step(1'b0, 1'b1, 3'd1, 32'd9, 32'd9);
      idle(MC);
      check("ign_hi", hi, 32'd0);
      check("ign_lo", lo, 32'd12);

      // reset in the 4th busy cycle of a divide aborts it
      done_seen = 0;
      step(1'b0, 1'b1, 3'd3, 32'd100, 32'd7);
      idle(2);
      step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      idle(DC + 2);
      check("abort_nodone", 32'(done_seen), 32'd0);

      // random traffic, including starts while busy and occasional resets
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
              3'($urandom_range(0, 7)), pick_val(), pick_val());
      end
      idle(DC + 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
